mem_access_unit: RTL and testbench

Data-memory access controller sitting directly downstream of the single-cycle datapath's ALU. It consumes the computed effective address, store data and the control unit's memory strobes (`RAMEnable`, `MOV`, `RW`), performs byte/halfword/word loads and stores against an internal byte-addressed array with a programmable wait-state latency, and returns load data plus the `MOC` completion strobe that the control unit waits on before writeback.

---
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access controller for the single-cycle datapath.
// It accepts one request per handshake and waits a programmable number of
// wait states. It then performs a big-endian byte/half/word load or store
// against an internal byte array and pulses moc for one cycle.
module mem_access_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ram_enable,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        moc,
  output logic        busy,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  stateT             state;
  logic [3:0]        waitCnt;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [1:0]        sizeQ;
  logic              rwQ;
  logic              signExtQ;
  logic [7:0]        mem [2**ADDR_W];

  logic              inIdle;
  logic              reqFire;
  logic              enterDone;
  logic              accessErr;
  logic [ADDR_W-1:0] effAddr;
  logic [ADDR_W-1:0] effAddr1;
  logic [ADDR_W-1:0] effAddr2;
  logic [ADDR_W-1:0] effAddr3;
  logic [31:0]       effWdata;
  logic [1:0]        effSize;
  logic              effRw;
  logic              effSext;
  logic [31:0]       beWord;
  logic              unusedAddrBits;

  // Half needs an even address, word needs a 4-byte aligned one, size 11 never succeeds.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // The big-endian word starts at the access address, so byte/half results sit in its top bits.
  function automatic logic [31:0] extendLoad(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] word);
    case (sz)
      2'b00:   return {{24{sx & word[31]}}, word[31:24]};
      2'b01:   return {{16{sx & word[31]}}, word[31:16]};
      default: return word;
    endcase
  endfunction

  // Upper address bits alias away; the array wraps modulo its size.
  assign unusedAddrBits = ^addr[31:ADDR_W];

  // In IDLE the live request drives the access, so a zero-wait build completes on the accept edge.
  always_comb begin
    inIdle    = (state == IDLE);
    reqFire   = inIdle && ram_enable && mov;
    effAddr   = inIdle ? addr[ADDR_W-1:0] : addrQ;
    effWdata  = inIdle ? wdata    : wdataQ;
    effSize   = inIdle ? size     : sizeQ;
    effRw     = inIdle ? rw       : rwQ;
    effSext   = inIdle ? sign_ext : signExtQ;
    effAddr1  = effAddr + ADDR_W'(1);
    effAddr2  = effAddr + ADDR_W'(2);
    effAddr3  = effAddr + ADDR_W'(3);
    beWord    = {mem[effAddr], mem[effAddr1], mem[effAddr2], mem[effAddr3]};
    accessErr = misaligned(effSize, effAddr[1:0]);
    enterDone = (reqFire && (WAIT_STATES == 0)) || (state == WAIT && waitCnt == 4'd1);
  end

  assign busy = (state != IDLE);

  // Request capture; frozen for the whole WAIT period.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      addrQ    <= addr[ADDR_W-1:0];
      wdataQ   <= wdata;
      sizeQ    <= size;
      rwQ      <= rw;
      signExtQ <= sign_ext;
    end
  end

  // Control FSM with registered moc/align_err/rdata; the access resolves on the edge into DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      moc       <= 1'b0;
      align_err <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      moc <= enterDone;
      case (state)
        IDLE: begin
          if (reqFire) begin
            waitCnt   <= 4'(WAIT_STATES);
            align_err <= 1'b0;
            state     <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (enterDone) begin
        align_err <= accessErr;
        if (!accessErr && effRw) rdata <= extendLoad(effSize, effSext, beWord);
      end
    end
  end

  // Array store, MSB byte at the access address; a reset in progress suppresses it.
  always_ff @(posedge clk) begin
    if (reset && enterDone && !accessErr && !effRw) begin
      case (effSize)
        2'b00: mem[effAddr] <= effWdata[7:0];
        2'b01: begin
          mem[effAddr]  <= effWdata[15:8];
          mem[effAddr1] <= effWdata[7:0];
        end
        default: begin
          mem[effAddr]  <= effWdata[31:24];
          mem[effAddr1] <= effWdata[23:16];
          mem[effAddr2] <= effWdata[15:8];
          mem[effAddr3] <= effWdata[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a default (2 wait-state) instance plus a zero-wait instance.
module tb_mem_access_unit;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ramEnable, mov, mov0, rw, signExt;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata0;
  logic        moc, busy, alignErr;
  logic        moc0, busy0, alignErr0;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.ADDR_W(9), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .ram_enable(ramEnable), .mov(mov), .rw(rw),
    .size(size), .sign_ext(signExt), .addr(addr), .wdata(wdata),
    .rdata(rdata), .moc(moc), .busy(busy), .align_err(alignErr)
  );

  mem_access_unit #(.ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .ram_enable(ramEnable), .mov(mov0), .rw(rw),
    .size(size), .sign_ext(signExt), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .moc(moc0), .busy(busy0), .align_err(alignErr0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request on the 2-wait instance; checks moc latency and returns with the unit idle.
  task automatic op(input string tag, input logic r, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    rw = r; size = sz; signExt = sx; addr = a; wdata = wd; ramEnable = 1'b1; mov = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      mov = 1'b0;
      n++;
    end while (!moc && n < 10);
    chk({tag, "_lat"}, 32'(n), 32'(WS + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    int mocCnt, busyLow, firstMoc;
    reset = 1'b0; ramEnable = 1'b0; mov = 1'b0; mov0 = 1'b0; rw = 1'b0;
    size = 2'b00; signExt = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk); #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_moc", 32'(moc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_align", 32'(alignErr), 32'd0);
    @(negedge clk); reset = 1'b1;

    op("st_w10", 1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
    chk("st_w10_err", 32'(alignErr), 32'd0);
    op("ld_w10", 1'b1, 2'b10, 1'b0, 32'h010, 32'd0);
    chk("ld_w10", rdata, 32'hDEADBEEF);
    chk("ld_w10_err", 32'(alignErr), 32'd0);
    op("ld_b11s", 1'b1, 2'b00, 1'b1, 32'h011, 32'd0);
    chk("ld_b11s", rdata, 32'hFFFFFFAD);
    op("ld_b11z", 1'b1, 2'b00, 1'b0, 32'h011, 32'd0);
    chk("ld_b11z", rdata, 32'h000000AD);
    op("ld_h12s", 1'b1, 2'b01, 1'b1, 32'h012, 32'd0);
    chk("ld_h12s", rdata, 32'hFFFFBEEF);
    op("st_b13", 1'b0, 2'b00, 1'b0, 32'h013, 32'h0000005A);
    op("ld_w10b", 1'b1, 2'b10, 1'b0, 32'h010, 32'd0);
    chk("ld_w10b", rdata, 32'hDEADBE5A);

    // Misaligned and illegal-size accesses
    op("ld_w12", 1'b1, 2'b10, 1'b0, 32'h012, 32'd0);
    chk("ld_w12_err", 32'(alignErr), 32'd1);
    chk("ld_w12_keep", rdata, 32'hDEADBE5A);
    op("st_w20", 1'b0, 2'b10, 1'b0, 32'h020, 32'h11223344);
    chk("st_w20_err", 32'(alignErr), 32'd0);
    op("st_h21", 1'b0, 2'b01, 1'b0, 32'h021, 32'h0000AAAA);
    chk("st_h21_err", 32'(alignErr), 32'd1);
    op("ld_w20", 1'b1, 2'b10, 1'b0, 32'h020, 32'd0);
    chk("ld_w20", rdata, 32'h11223344);
    chk("ld_w20_err", 32'(alignErr), 32'd0);
    op("ld_sz3", 1'b1, 2'b11, 1'b0, 32'h020, 32'd0);
    chk("ld_sz3_err", 32'(alignErr), 32'd1);

    // Aliasing and the top word of the array
    op("ld_alias", 1'b1, 2'b10, 1'b0, 32'h220, 32'd0);
    chk("ld_alias", rdata, 32'h11223344);
    op("st_top", 1'b0, 2'b10, 1'b0, 32'h1FC, 32'hCAFEF00D);
    op("ld_top", 1'b1, 2'b10, 1'b0, 32'h1FC, 32'd0);
    chk("ld_top", rdata, 32'hCAFEF00D);

    // mov held high: back-to-back reads
    @(negedge clk);
    rw = 1'b1; size = 2'b10; signExt = 1'b0; addr = 32'h010; ramEnable = 1'b1; mov = 1'b1;
    mocCnt = 0; busyLow = 0; firstMoc = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (moc) begin
        mocCnt++;
        if (firstMoc == 0) firstMoc = i;
      end
      if (!busy) busyLow++;
    end
    mov = 1'b0;
    chk("held_first", 32'(firstMoc), 32'd3);
    chk("held_mocs", 32'(mocCnt), 32'd4);
    chk("held_busylow", 32'(busyLow), 32'd4);
    chk("held_rdata", rdata, 32'hDEADBE5A);
    @(posedge clk); #1;

    // Zero-wait instance: moc on the accept edge
    @(negedge clk);
    rw = 1'b0; size = 2'b10; addr = 32'h008; wdata = 32'hA5A5A5A5; mov0 = 1'b1;
    @(posedge clk); #1;
    mov0 = 1'b0;
    chk("ws0_st_moc", 32'(moc0), 32'd1);
    @(posedge clk); #1;
    chk("ws0_st_pulse", 32'(moc0), 32'd0);
    @(negedge clk);
    rw = 1'b1; mov0 = 1'b1;
    @(posedge clk); #1;
    mov0 = 1'b0;
    chk("ws0_ld_moc", 32'(moc0), 32'd1);
    chk("ws0_ld_data", rdata0, 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Reset during WAIT aborts a store
    op("st_w40", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0BADCAFE);
    @(negedge clk);
    rw = 1'b0; size = 2'b10; addr = 32'h040; wdata = 32'h12345678; mov = 1'b1;
    @(posedge clk); #1;
    mov = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_moc", 32'(moc), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    op("ld_w40", 1'b1, 2'b10, 1'b0, 32'h040, 32'd0);
    chk("ld_w40", rdata, 32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
